// File: rtl/fetch_decode_queue.sv
// Instruction prefetch queue between Fetch and Decode.
// Circular buffer of {InstrF, PCF, PCPlus4F} entries with first-word
// fall-through head outputs, synchronous flush and asynchronous reset.
module fetch_decode_queue #(
  parameter int WIDTH       = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           PCF,
  input  logic [WIDTH-1:0]           PCPlus4F,
  input  logic [INSTR_WIDTH-1:0]     InstrF,
  input  logic                       validF,
  output logic                       readyF,
  input  logic                       flushD,
  input  logic                       stallD,
  output logic [INSTR_WIDTH-1:0]     InstrD,
  output logic [WIDTH-1:0]           PCD,
  output logic [WIDTH-1:0]           PCPlus4D,
  output logic                       validD,
  output logic [$clog2(DEPTH+1)-1:0] countQ
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = 2 * WIDTH + INSTR_WIDTH;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Entry layout: {instr, pc, pc_plus4}
  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_ready;
  logic               w_valid;
  logic               w_push;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_head;

  // Flow control depends only on registered occupancy; no path from stallD/validF to readyF.
  assign w_ready = (r_count < FULL_CNT);
  assign w_valid = (r_count != {CNT_W{1'b0}});
  assign w_push  = validF & w_ready & ~flushD;
  assign w_pop   = w_valid & ~stallD & ~flushD;

  assign readyF  = w_ready;
  assign validD  = w_valid;
  assign countQ  = r_count;

  // Storage write; contents need no reset because validD gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {InstrF, PCF, PCPlus4F};
    end
  end

  // Pointer and occupancy update; flush overrides any same-cycle push or pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= {PTR_W{1'b0}};
      r_wr_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else if (flushD) begin
      r_rd_ptr <= {PTR_W{1'b0}};
      r_wr_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      // DEPTH is a power of two, so pointer increments wrap naturally.
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head presentation: fall-through of entry[rd_ptr], forced to zero when empty.
  always_comb begin
    w_head   = r_mem[r_rd_ptr];
    InstrD   = {INSTR_WIDTH{1'b0}};
    PCD      = {WIDTH{1'b0}};
    PCPlus4D = {WIDTH{1'b0}};
    if (w_valid) begin
      InstrD   = w_head[ENTRY_W-1 -: INSTR_WIDTH];
      PCD      = w_head[2*WIDTH-1 -: WIDTH];
      PCPlus4D = w_head[WIDTH-1:0];
    end else begin
      InstrD   = {INSTR_WIDTH{1'b0}};
      PCD      = {WIDTH{1'b0}};
      PCPlus4D = {WIDTH{1'b0}};
    end
  end

endmodule
